// File: rtl/branch_cmp_pipe.sv
// Pipelined RV32I branch comparator with valid/ready handshake, result tag and flush.
// Optional out_illegal flag when BRANCH_CMP_ILLEGAL_FLAG_EN is defined.
module branch_cmp_pipe #(
  parameter int WIDTH       = 32,
  parameter int TAG_W       = 5,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cmpop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_en,
  output logic [TAG_W-1:0] out_tag
`ifdef BRANCH_CMP_ILLEGAL_FLAG_EN
  ,
  output logic             out_illegal
`endif
);

  // Illegal funct3 codes fall into the default arm and resolve not-taken.
  function automatic logic resolve(input logic [2:0] op, input logic eq, input logic lt);
    case (op)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return lt;
      3'b111:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

`ifdef BRANCH_CMP_ILLEGAL_FLAG_EN
  function automatic logic isIllegal(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction
`endif

  if (PIPE_STAGES == 2) begin : g_split
    localparam int H = WIDTH / 2;

    logic                 r1_valid;
    logic                 r1_lo_eq;
    logic                 r1_lo_ltu;
    logic [WIDTH-H-1:0]   r1_a_hi;
    logic [WIDTH-H-1:0]   r1_b_hi;
    logic [2:0]           r1_op;
    logic [TAG_W-1:0]     r1_tag;
    logic                 r2_valid;
    logic                 r2_br_en;
    logic [TAG_W-1:0]     r2_tag;
    logic                 w2_load;
    logic                 w1_load;
    logic                 w_accept;
    logic                 w_hi_eq;
    logic                 w_hi_lt;
    logic                 w_eq;
    logic                 w_lt;

    assign w2_load  = !r2_valid || out_ready;
    assign w1_load  = !r1_valid || w2_load;
    assign in_ready = !rst && !flush && w1_load;
    assign w_accept = in_valid && in_ready;

    // High halves are signed only for blt/bge (cmpop[1] clear).
    assign w_hi_eq = (r1_a_hi == r1_b_hi);
    assign w_hi_lt = r1_op[1] ? (r1_a_hi < r1_b_hi)
                              : ($signed(r1_a_hi) < $signed(r1_b_hi));
    assign w_lt    = w_hi_lt | (w_hi_eq & r1_lo_ltu);
    assign w_eq    = w_hi_eq & r1_lo_eq;

    always_ff @(posedge clk) begin
      if (rst) begin
        r1_valid  <= 1'b0;
        r1_lo_eq  <= 1'b0;
        r1_lo_ltu <= 1'b0;
        r1_a_hi   <= '0;
        r1_b_hi   <= '0;
        r1_op     <= '0;
        r1_tag    <= '0;
        r2_valid  <= 1'b0;
        r2_br_en  <= 1'b0;
        r2_tag    <= '0;
      end else if (flush) begin
        r1_valid <= 1'b0;
        r2_valid <= 1'b0;
      end else begin
        if (w1_load) begin
          r1_valid <= w_accept;
          if (w_accept) begin
            r1_lo_eq  <= (a[H-1:0] == b[H-1:0]);
            r1_lo_ltu <= (a[H-1:0] <  b[H-1:0]);
            r1_a_hi   <= a[WIDTH-1:H];
            r1_b_hi   <= b[WIDTH-1:H];
            r1_op     <= cmpop;
            r1_tag    <= in_tag;
          end
        end
        if (w2_load) begin
          r2_valid <= r1_valid;
          if (r1_valid) begin
            r2_br_en <= resolve(r1_op, w_eq, w_lt);
            r2_tag   <= r1_tag;
          end
        end
      end
    end

    assign out_valid = r2_valid;
    assign br_en     = r2_br_en;
    assign out_tag   = r2_tag;

`ifdef BRANCH_CMP_ILLEGAL_FLAG_EN
    logic r2_illegal;
    always_ff @(posedge clk) begin
      if (rst) begin
        r2_illegal <= 1'b0;
      end else if (!flush && w2_load && r1_valid) begin
        r2_illegal <= isIllegal(r1_op);
      end
    end
    assign out_illegal = r2_illegal;
`endif
  end else begin : g_full
    logic             r_valid;
    logic             r_br_en;
    logic [TAG_W-1:0] r_tag;
    logic             w_load;
    logic             w_accept;
    logic             w_eq;
    logic             w_lt;

    assign w_load   = !r_valid || out_ready;
    assign in_ready = !rst && !flush && w_load;
    assign w_accept = in_valid && in_ready;
    assign w_eq     = (a == b);
    assign w_lt     = cmpop[1] ? (a < b) : ($signed(a) < $signed(b));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_br_en <= 1'b0;
        r_tag   <= '0;
      end else if (flush) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= w_accept;
        if (w_accept) begin
          r_br_en <= resolve(cmpop, w_eq, w_lt);
          r_tag   <= in_tag;
        end
      end
    end

    assign out_valid = r_valid;
    assign br_en     = r_br_en;
    assign out_tag   = r_tag;

`ifdef BRANCH_CMP_ILLEGAL_FLAG_EN
    logic r_illegal;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_illegal <= 1'b0;
      end else if (!flush && w_load && w_accept) begin
        r_illegal <= isIllegal(cmpop);
      end
    end
    assign out_illegal = r_illegal;
`endif
  end

endmodule
